// File: rtl/acc_pkg.sv
// Shared types and default widths for the serial accumulator sequencer.
// Bit order is selected at build time with ACC_SEQ_MSB_FIRST_EN (see acc_seq).
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } acc_seq_state_t;

  localparam int ACC_W     = 8;
  localparam int ACC_CNT_W = 8;

  // Width needed for a counter that must reach the value w inclusive.
  function automatic int bitcnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/acc_seq_shreg.sv
// Load/shift/collect register pair for acc_seq.
// The outgoing register serialises the accepted word; the result register
// collects the datapath's serial response. Shift direction follows
// ACC_SEQ_MSB_FIRST_EN: undefined = LSB first, defined = MSB first.
module acc_seq_shreg
  import acc_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_shift,
  input  logic         i_sample,
  input  logic         i_y,
  output logic         o_bit,
  output logic [W-1:0] o_res
);

  logic [W-1:0] r_sh;
  logic [W-1:0] r_res;

  // Outgoing word: loaded on accept, advanced by one bit per strobe cycle
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
`ifdef ACC_SEQ_MSB_FIRST_EN
      r_sh <= {r_sh[W-2:0], 1'b0};
`else
      r_sh <= {1'b0, r_sh[W-1:1]};
`endif
    end
  end

  // Result: the first sample ends at the first-sent bit position after W samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res <= '0;
    end else if (i_sample) begin
`ifdef ACC_SEQ_MSB_FIRST_EN
      r_res <= {r_res[W-2:0], i_y};
`else
      r_res <= {i_y, r_res[W-1:1]};
`endif
    end
  end

`ifdef ACC_SEQ_MSB_FIRST_EN
  assign o_bit = r_sh[W-1];
`else
  assign o_bit = r_sh[0];
`endif

  assign o_res = r_res;

endmodule

// File: rtl/acc_seq.sv
// Word-to-serial sequencer for the 1-bit serial accumulator datapath.
// Accepts a W-bit word, strobes it into the datapath one bit per cycle,
// collects the registered serial response and hands it off over valid/ready.
// Build option: define ACC_SEQ_MSB_FIRST_EN for MSB-first send and collect.
module acc_seq
  import acc_pkg::*;
#(
  parameter int W            = ACC_W,
  parameter int CNT_W        = ACC_CNT_W,
  parameter bit CLR_ON_START = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             acc_a,
  output logic             acc_iclk,
  output logic             acc_clr,
  input  logic             acc_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             busy,
  output logic [CNT_W-1:0] words_done
);

  localparam int              BC_W     = bitcnt_w(W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(W - 1);

  acc_seq_state_t   r_state;
  logic [BC_W-1:0]  r_bit_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_iclk;
  logic             r_clr;
  logic [CNT_W-1:0] r_words;

  logic             w_accept;
  logic             w_shift;
  logic             w_sample;
  logic             w_bit;
  logic [W-1:0]     w_res;

  assign w_accept = in_valid & r_in_ready;
  assign w_shift  = (r_state == SHIFT);
  // y lags its strobe by one cycle: first sample is in the second SHIFT
  // cycle, the last one lands in CAPT.
  assign w_sample = (w_shift && (r_bit_cnt != '0)) || (r_state == CAPT);

  acc_seq_shreg #(
    .W (W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept),
    .i_data   (in_data),
    .i_shift  (w_shift),
    .i_sample (w_sample),
    .i_y      (acc_y),
    .o_bit    (w_bit),
    .o_res    (w_res)
  );

  // Sequencer FSM with registered handshake, strobe, clear and word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_iclk      <= 1'b0;
      r_clr       <= 1'b0;
      r_words     <= '0;
    end else begin
      r_clr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= SHIFT;
            r_bit_cnt  <= '0;
            r_in_ready <= 1'b0;
            r_iclk     <= 1'b1;
            r_clr      <= CLR_ON_START;
          end
        end
        SHIFT: begin
          r_bit_cnt <= r_bit_cnt + BC_W'(1);
          if (r_bit_cnt == LAST_BIT) begin
            r_state <= CAPT;
            r_iclk  <= 1'b0;
          end
        end
        CAPT: begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_words     <= r_words + CNT_W'(1);
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign acc_iclk   = r_iclk;
  assign acc_a      = r_iclk & w_bit;
  assign acc_clr    = r_clr;
  assign out_valid  = r_out_valid;
  assign out_data   = w_res;
  assign busy       = (r_state != IDLE);
  assign words_done = r_words;

endmodule

// File: tb/tb_acc_seq.sv
// Self-checking bench for acc_seq with a behavioural serial datapath model.
// Honours ACC_SEQ_MSB_FIRST_EN for the expected bit order.
`timescale 1ns/1ps
module tb_acc_seq;

  localparam int W     = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             acc_a;
  logic             acc_iclk;
  logic             acc_clr;
  logic             acc_y;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             busy;
  logic [CNT_W-1:0] words_done;

  int               n_chk = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic             inv_r = 1'b0;

  acc_seq #(
    .W            (W),
    .CNT_W        (CNT_W),
    .CLR_ON_START (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .acc_a      (acc_a),
    .acc_iclk   (acc_iclk),
    .acc_clr    (acc_clr),
    .acc_y      (acc_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .words_done (words_done)
  );

  always #5 clk = ~clk;

  // Datapath model: pass-through (or inverting) flop on strobe, noise otherwise
  always @(posedge clk) begin
    if (acc_iclk) acc_y <= inv_r ? ~acc_a : acc_a;
    else          acc_y <= 1'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Which word bit goes out in serial slot i
  function automatic logic sent_bit(input logic [W-1:0] d, input int i);
`ifdef ACC_SEQ_MSB_FIRST_EN
    return d[W-1-i];
`else
    return d[i];
`endif
  endfunction

  task automatic chk_reset_state();
    chk("rst_ctl", {26'd0, in_ready, out_valid, acc_a, acc_iclk, acc_clr, busy}, 32'b100000);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_cnt", {24'd0, words_done}, 32'd0);
  endtask

  // One full word; called at a negedge with the DUT idle
  task automatic xfer(input logic [W-1:0] d, input logic inv, input int hold);
    logic [W-1:0] exp_a, exp_y, sa, iv, cv, bv;
    for (int i = 0; i < W; i++) exp_a[i] = sent_bit(d, i);
    exp_y = inv ? ~d : d;
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    inv_r     = inv;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    for (int i = 0; i < W; i++) begin
      sa[i] = acc_a;
      iv[i] = acc_iclk;
      cv[i] = acc_clr;
      bv[i] = busy & ~in_ready;
      @(negedge clk);
    end
    chk("a_seq", {24'd0, sa}, {24'd0, exp_a});
    chk("iclk_seq", {24'd0, iv}, 32'hFF);
    chk("clr_seq", {24'd0, cv}, 32'h01);
    chk("busy_seq", {24'd0, bv}, 32'hFF);
    chk("capt", {29'd0, acc_iclk, acc_clr, out_valid}, 32'd0);
    @(negedge clk);
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("out_data", {24'd0, out_data}, {24'd0, exp_y});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      @(negedge clk);
      chk("hold", {22'd0, out_valid, in_ready, out_data}, {22'd0, 1'b1, 1'b0, exp_y});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_cnt   = exp_cnt + CNT_W'(1);
    @(negedge clk);
    chk("handoff", {29'd0, out_valid, in_ready, busy}, 32'b010);
    chk("words_done", {24'd0, words_done}, {24'd0, exp_cnt});
  endtask

  // Start a word and reset during its 4th SHIFT cycle
  task automatic abort_word(input logic [W-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state();
    rst     = 1'b0;
    exp_cnt = '0;
  endtask

  // Back-to-back stream with in_valid and out_ready held high
  task automatic b2b();
    logic [W-1:0] q[$];
    logic [W-1:0] e;
    int acc_n = 0, hand_n = 0, last_acc = -1, cyc = 0;
    inv_r     = 1'($urandom);
    in_data   = W'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (hand_n < 256 && cyc < 256 * 11 + 100) begin
      if (out_valid) begin
        chk("b2b_cnt", {24'd0, words_done}, 32'(hand_n % 256));
        if (q.size() == 0) chk("b2b_queue", 32'd0, 32'd1);
        else begin
          e = q.pop_front();
          chk("b2b_data", {24'd0, out_data}, {24'd0, e});
        end
        hand_n++;
        in_data  = W'($urandom);
        inv_r    = 1'($urandom);
        in_valid = (acc_n < 256);
      end
      if (in_ready && in_valid) begin
        if (last_acc >= 0) chk("b2b_gap", 32'(cyc - last_acc), 32'd11);
        last_acc = cyc;
        q.push_back(inv_r ? ~in_data : in_data);
        acc_n++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_count", 32'(hand_n), 32'd256);
    chk("b2b_wrap", {24'd0, words_done}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    exp_cnt   = '0;
    repeat (3) @(negedge clk);
    chk_reset_state();
    rst = 1'b0;
    @(negedge clk);

    xfer(8'hA5, 1'b0, 0);
    xfer(8'h0F, 1'b1, 0);
    xfer(8'h80, 1'b0, 0);
    xfer(8'h5A, 1'b0, 20);
    for (int k = 0; k < 40; k++)
      xfer(W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    abort_word(8'hC3);
    xfer(8'h3C, 1'b0, 0);

    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    exp_cnt = '0;
    chk_reset_state();
    b2b();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/acc_seq.md
Name: acc_seq

Overview:
- Sequencer for the 1-bit serial accumulator datapath (ports a, iclk, y).
- Accepts W-bit words over a valid/ready handshake and drives each word bit-serially into the datapath, one bit per cycle with an iclk strobe.
- Collects the datapath's serial y response into a W-bit result and presents it over a valid/ready output handshake.
- Sits between the word-level control logic and the acc instance. Also owns the datapath clear pulse and a completed-word counter.

Parameters:
- W, 8, word width in bits (2..32).
- CNT_W, 8, width of the completed-word counter.
- CLR_ON_START, 1, 1 = pulse acc_clr on every accepted word; 0 = never pulse.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  word request.
- in_ready  out  1  block can accept a word.
- in_data  in  W  word to serialize.
- acc_a  out  1  serial data bit to datapath input a.
- acc_iclk  out  1  datapath bit strobe (iclk); high exactly one cycle per bit.
- acc_clr  out  1  one-cycle datapath clear pulse.
- acc_y  in  1  datapath serial output; registered in the datapath, valid the cycle after its strobe.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_data  out  W  collected result.
- busy  out  1  state != IDLE.
- words_done  out  CNT_W  count of results handed off; wraps.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, in_ready=1, out_valid=0, acc_a=0, acc_iclk=0, acc_clr=0, out_data=0, words_done=0, bit counter=0.
- Reset mid-word aborts the word, discards the partial result and drops acc_iclk at that same edge. The datapath is not reset by this block.
- in_ready=1 only in IDLE. Accept = in_valid & in_ready at an edge.
- States and transitions:
  - IDLE: on accept, load shift register with in_data, bit counter=0, acc_clr=CLR_ON_START for the next cycle, go to SHIFT.
  - SHIFT: drive acc_a = shreg LSB, acc_iclk=1, shift right, counter++. From the second SHIFT cycle on, shift the acc_y sample into result bit (counter-1). After W SHIFT cycles, go to CAPT.
  - CAPT: acc_iclk=0, acc_a=0. Capture the last acc_y into bit W-1. Go to DONE.
  - DONE: out_valid=1 and out_data stable. On out_valid & out_ready: out_valid=0, words_done++, go to IDLE.
- acc_clr is asserted during the first SHIFT cycle, coincident with the first strobe. The datapath treats clr as taking priority over the bit update.
- Latency: accept at edge t. SHIFT occupies cycles t+1..t+W, CAPT is t+W+1, out_valid is high from t+W+2.
- Throughput: one word per W+3 cycles minimum (back-to-back, out_ready held high).
- out_ready low holds DONE indefinitely; out_data does not change. in_ready stays 0, so there is no input buffering.
- in_valid while busy is ignored; in_data need only be stable at the accept edge.
- words_done wraps from 2^CNT_W-1 to 0 with no flag.
- acc_y is ignored outside the W sample cycles.

Optional Feature:
- Macro ACC_SEQ_MSB_FIRST_EN.
- Defined: bits are sent MSB first (shift left, acc_a = shreg MSB) and collected MSB first (result bit W-1 captured first, bit 0 captured in CAPT).
- Undefined: LSB-first order as above.
- Latency, handshakes and counter behaviour are identical in both builds.

Decomposition:
- Shared package acc_pkg: state enum acc_seq_state_t {IDLE, SHIFT, CAPT, DONE}, default widths ACC_W=8 and ACC_CNT_W=8.
- One natural sub-module: acc_seq_shreg, a W-bit bidirectional load/shift/collect register controlled by the FSM.
- FSM and counters stay in acc_seq.

Test Plan:
- Bench datapath model: y(t+1) = a(t) when iclk=1 (pass-through flop); the invert variant gives y(t+1) = ~a(t).
- Reset, then one word 8'hA5 with out_ready=1 -> acc_a sequence 1,0,1,0,0,1,0,1 (LSB first) with acc_iclk high 8 cycles; out_data=8'hA5; out_valid exactly 10 cycles after the accept edge; words_done=1.
- Invert model, word 8'h0F -> out_data=8'hF0. acc_clr high only in the first SHIFT cycle when CLR_ON_START=1, and never high when CLR_ON_START=0.
- out_ready held 0 for 20 cycles after out_valid -> out_data and out_valid stable, in_ready=0, in_valid pulses ignored. Releasing out_ready -> handoff, then IDLE next cycle.
- rst asserted in the 4th SHIFT cycle -> next cycle all outputs at reset values. A following word 8'h3C completes correctly.
- 256 back-to-back words with in_valid and out_ready held 1 -> one accept every 11 cycles; words_done wraps to 0. With ACC_SEQ_MSB_FIRST_EN defined, word 8'h80 -> first acc_a bit is 1 and out_data=8'h80.
